// File: rtl/debug_controller_pkg.sv
// Shared definitions for the debug sequencer.
// State encoding, default command bytes and dump length.
package debug_controller_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        RUN       = 3'b001,
        STEP      = 3'b010,
        SEND_LOAD = 3'b011,
        SEND_WAIT = 3'b100,
        DONE      = 3'b101
    } state_t;

    localparam int         DUMP_BYTES_DEF = 128;
    localparam logic [7:0] CMD_CONT_DEF   = 8'h63;
    localparam logic [7:0] CMD_STEP_DEF   = 8'h73;

endpackage

// File: rtl/debug_controller.sv
// Debug sequencer: runs or single-steps the datapath on a
// UART command, then streams a fixed-length state dump back.
module debug_controller
    import debug_controller_pkg::*;
#(
    parameter int         DUMP_BYTES = DUMP_BYTES_DEF,
    parameter logic [7:0] CMD_CONT   = CMD_CONT_DEF,
    parameter logic [7:0] CMD_STEP   = CMD_STEP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_done,
    input  logic       cpu_halted,
    input  logic [7:0] dump_data,
    output logic       cpu_enable,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] send_counter,
    output logic       sent_flag,
    output logic       led_idle
);

    localparam logic [7:0] LAST_IDX = 8'(DUMP_BYTES - 1);

    state_t state;
    logic   is_cont;
    logic   is_step;

    assign is_cont = (rx_data == CMD_CONT);
    assign is_step = (rx_data == CMD_STEP);

    // Single FSM; every output is registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpu_enable   <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            send_counter <= 8'h00;
            sent_flag    <= 1'b0;
            led_idle     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_done && (is_cont || is_step)) begin
                        sent_flag    <= 1'b0;
                        send_counter <= 8'h00;
                        led_idle     <= 1'b0;
                        if (cpu_halted) begin
                            state <= SEND_LOAD;
                        end else if (is_cont) begin
                            state      <= RUN;
                            cpu_enable <= 1'b1;
                        end else begin
                            state      <= STEP;
                            cpu_enable <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cpu_halted) begin
                        state      <= SEND_LOAD;
                        cpu_enable <= 1'b0;
                    end
                end
                STEP: begin
                    state      <= SEND_LOAD;
                    cpu_enable <= 1'b0;
                end
                SEND_LOAD: begin
                    tx_data  <= dump_data;
                    tx_start <= 1'b1;
                    state    <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done) begin
                        if (send_counter == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            send_counter <= send_counter + 8'd1;
                            state        <= SEND_LOAD;
                        end
                    end
                end
                DONE: begin
                    sent_flag    <= 1'b1;
                    send_counter <= 8'h00;
                    led_idle     <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    cpu_enable <= 1'b0;
                    tx_start   <= 1'b0;
                    led_idle   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_controller.sv
// Randomised scoreboard bench for debug_controller.
// Two instances: a short 4-byte dump and a full 256-byte dump.
module tb_debug_controller;

    localparam logic [7:0] C_CONT = 8'h63;
    localparam logic [7:0] C_STEP = 8'h73;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] rx_data_a = 8'h00;
    logic       rx_done_a = 1'b0;
    logic       tx_done_ra = 1'b0;
    logic       tx_done_sa = 1'b0;
    logic       halted_a = 1'b0;
    logic [7:0] dump_a;
    logic       en_a, txs_a, sent_a, idle_a;
    logic [7:0] txd_a, cnt_a;
    logic [7:0] mem_a [4];

    logic [7:0] rx_data_b = 8'h00;
    logic       rx_done_b = 1'b0;
    logic       tx_done_b = 1'b0;
    logic       halted_b = 1'b0;
    logic [7:0] dump_b;
    logic       en_b, txs_b, sent_b, idle_b;
    logic [7:0] txd_b, cnt_b;
    logic [7:0] mem_b [256];

    assign dump_a = mem_a[cnt_a[1:0]];
    assign dump_b = mem_b[cnt_b];

    debug_controller #(.DUMP_BYTES(4)) dut_a (
        .clk(clk), .reset(reset),
        .rx_data(rx_data_a), .rx_done(rx_done_a),
        .tx_done(tx_done_ra | tx_done_sa),
        .cpu_halted(halted_a), .dump_data(dump_a),
        .cpu_enable(en_a), .tx_start(txs_a), .tx_data(txd_a),
        .send_counter(cnt_a), .sent_flag(sent_a),
        .led_idle(idle_a)
    );

    debug_controller #(.DUMP_BYTES(256)) dut_b (
        .clk(clk), .reset(reset),
        .rx_data(rx_data_b), .rx_done(rx_done_b),
        .tx_done(tx_done_b),
        .cpu_halted(halted_b), .dump_data(dump_b),
        .cpu_enable(en_b), .tx_start(txs_b), .tx_data(txd_b),
        .send_counter(cnt_b), .sent_flag(sent_b),
        .led_idle(idle_b)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t tx_qa[$];
    exp_t tx_qb[$];
    int   en_qa[$];
    int   max_b = 0;
    bit   en_b_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " en"}, en_a, 0);
        check({tag, " tx_start"}, txs_a, 0);
        check({tag, " tx_data"}, txd_a, 0);
        check({tag, " counter"}, cnt_a, 0);
        check({tag, " sent"}, sent_a, 0);
        check({tag, " idle"}, idle_a, 1);
    endtask

    // tx scoreboard, instance A
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && txs_a) begin
                if (tx_qa.size() == 0) begin
                    bad("tx_a unexpected byte");
                end else begin
                    e = tx_qa.pop_front();
                    check("tx_a idx", cnt_a, e.idx);
                    check("tx_a data", txd_a, e.data);
                end
            end
        end
    end

    // enable-run-length scoreboard, instance A
    initial begin
        int  len;
        logic prev;
        len = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                len = 0;
                prev = 1'b0;
            end else begin
                if (en_a) begin
                    len++;
                end else if (prev) begin
                    if (en_qa.size() == 0) bad("en_a unexpected run");
                    else check("en_a run length", len, en_qa.pop_front());
                    len = 0;
                end
                prev = en_a;
            end
        end
    end

    // tx scoreboard, instance B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (int'(cnt_b) > max_b) max_b = int'(cnt_b);
            if (en_b) en_b_seen = 1'b1;
            if (!reset && txs_b) begin
                if (tx_qb.size() == 0) begin
                    bad("tx_b unexpected byte");
                end else begin
                    e = tx_qb.pop_front();
                    check("tx_b idx", cnt_b, e.idx);
                    check("tx_b data", txd_b, e.data);
                end
            end
        end
    end

    // transmitter model A: random delay, 0 = same-cycle done
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (txs_a && !reset) begin
                d = $urandom_range(0, 4);
                if (d != 0) repeat (d) @(negedge clk);
                tx_done_ra = 1'b1;
                @(negedge clk);
                tx_done_ra = 1'b0;
            end
        end
    end

    // transmitter model B
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (txs_b && !reset) begin
                d = $urandom_range(0, 1);
                if (d != 0) @(negedge clk);
                tx_done_b = 1'b1;
                @(negedge clk);
                tx_done_b = 1'b0;
            end
        end
    end

    task automatic push_dump_a();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.idx = 8'(k);
            e.data = mem_a[k];
            tx_qa.push_back(e);
        end
    endtask

    task automatic wait_idle_a(input string tag);
        int k;
        k = 0;
        while (!idle_a && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) bad({tag, " timeout"});
    endtask

    task automatic cmd_a(input logic [7:0] c, input bit halt,
                         input int n);
        bit   acc;
        bit   meas;
        int   lat;
        logic prior;
        acc = (c == C_CONT) || (c == C_STEP);
        meas = acc && (halt || c == C_STEP);
        prior = sent_a;
        for (int k = 0; k < 4; k++) mem_a[k] = 8'($urandom);
        if (acc) begin
            push_dump_a();
            if (!halt) en_qa.push_back((c == C_CONT) ? n : 1);
        end
        halted_a = halt;
        rx_data_a = c;
        rx_done_a = 1'b1;
        if (meas) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (lat == 1) begin
                    rx_done_a = 1'b0;
                    check("en at cycle 1", en_a, !halt);
                    check("idle after cmd", idle_a, 0);
                end
            end while (!txs_a && lat < 10);
            check("first tx latency", lat, halt ? 2 : 3);
        end else begin
            @(negedge clk);
            rx_done_a = 1'b0;
            if (acc) begin
                repeat (n - 1) @(negedge clk);
                halted_a = 1'b1;
                repeat (2) @(negedge clk);
                halted_a = 1'b0;
            end
        end
        rx_data_a = 8'($urandom);
        if (acc) begin
            wait_idle_a("dump");
            check("sent after dump", sent_a, 1);
            check("counter after dump", cnt_a, 0);
            check("en after dump", en_a, 0);
        end else begin
            repeat (5) @(negedge clk);
            check("ignored en", en_a, 0);
            check("ignored tx_start", txs_a, 0);
            check("ignored idle", idle_a, 1);
            check("ignored sent", sent_a, prior);
        end
        halted_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   k;
        int   r;
        logic [7:0] c;
        exp_t e;
        for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_a("in reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_a("after release");
        check("b idle", idle_b, 1);

        cmd_a(C_STEP, 1'b0, 0);
        cmd_a(C_CONT, 1'b0, 50);
        cmd_a(8'h41, 1'b0, 0);
        cmd_a(C_STEP, 1'b1, 0);
        cmd_a(C_CONT, 1'b1, 0);

        tx_done_sa = 1'b1;
        @(negedge clk);
        tx_done_sa = 1'b0;
        repeat (3) @(negedge clk);
        check("stray tx_done counter", cnt_a, 0);
        check("stray tx_done idle", idle_a, 1);

        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 4);
            c = (r < 2) ? C_CONT : (r < 4) ? C_STEP : 8'($urandom);
            cmd_a(c, ($urandom_range(0, 3) == 0), $urandom_range(1, 20));
        end

        for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
        push_dump_a();
        en_qa.push_back(1);
        rx_data_a = C_STEP;
        rx_done_a = 1'b1;
        @(negedge clk);
        rx_done_a = 1'b0;
        k = 0;
        while (!(txs_a && cnt_a == 8'd1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) bad("wait byte 1 timeout");
        rx_data_a = C_CONT;
        rx_done_a = 1'b1;
        @(negedge clk);
        rx_done_a = 1'b0;
        k = 0;
        while (cnt_a != 8'd2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) bad("wait byte 2 timeout");
        #2 reset = 1'b1;
        #1 check_reset_a("async reset");
        tx_qa.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_a("post reset idle");
        cmd_a(C_STEP, 1'b0, 0);

        halted_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            e.idx = 8'(i);
            e.data = mem_b[i];
            tx_qb.push_back(e);
        end
        max_b = 0;
        rx_data_b = C_CONT;
        rx_done_b = 1'b1;
        @(negedge clk);
        rx_done_b = 1'b0;
        k = 0;
        while (!idle_b && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) bad("b dump timeout");
        check("b max counter", max_b, 255);
        check("b counter end", cnt_b, 0);
        check("b sent", sent_b, 1);
        check("b en never", en_b_seen, 0);
        repeat (20) @(negedge clk);
        check("b bytes left", tx_qb.size(), 0);

        check("a bytes left", tx_qa.size(), 0);
        check("a runs left", en_qa.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
